m_lsu: RTL

Load/store unit for the single-cycle-memory MIPS datapath: accepts one memory request at a time from the M stage over a valid/ready handshake and drives the data-memory port (address, write data, write enable, byte-select). Word and byte operations are one memory access each. Halfword operations are split into two sequential byte accesses. The unit sign- or zero-extends load data and returns one response pulse per request. Misaligned and out-of-range requests are rejected without touching memory.

---
 rtl/m_lsu_pkg.sv | 41 ++++
 rtl/m_lsu_ext.sv | 25 ++
 rtl/m_lsu.sv | 124 ++++++++++++
 3 files changed

// File: rtl/m_lsu_pkg.sv
// Shared definitions for the load/store unit: op encoding, FSM states and
// alignment helpers used at request acceptance.
package m_lsu_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LB  = 3'd1;
  localparam logic [2:0] OP_LBU = 3'd2;
  localparam logic [2:0] OP_LH  = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SB  = 3'd6;
  localparam logic [2:0] OP_SH  = 3'd7;

  // Address bits that must be zero for word and halfword accesses.
  localparam logic [1:0] MASK_WORD = 2'b11;
  localparam logic [1:0] MASK_HALF = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC0 = 2'd1,
    S_ACC1 = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
  endfunction

  function automatic logic is_half(input logic [2:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lsb);
    logic bad;
    bad = 1'b0;
    if (op == OP_LW || op == OP_SW) bad = |(lsb & MASK_WORD);
    else if (is_half(op))           bad = |(lsb & MASK_HALF);
    return bad;
  endfunction

endpackage

// File: rtl/m_lsu_ext.sv
// Load extender: builds the 32-bit load result from the captured word or the
// low/high bytes; stores and unknown ops yield zero.
module m_lsu_ext
  import m_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [7:0]  lo,
  input  logic [7:0]  hi,
  input  logic [31:0] word,
  output logic [31:0] data
);

  always_comb begin
    data = 32'd0;
    case (op)
      OP_LW:   data = word;
      OP_LB:   data = {{24{lo[7]}}, lo};
      OP_LBU:  data = {24'd0, lo};
      OP_LH:   data = {{16{hi[7]}}, hi, lo};
      OP_LHU:  data = {16'd0, hi, lo};
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/m_lsu.sv
// Load/store unit: one request at a time over valid/ready, halfwords split
// into two byte accesses, one response pulse per accepted request.
module m_lsu
  import m_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        dm_we,
  output logic        dm_byte,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd,
  output logic [31:0] dm_pc,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE outside reset, and responses cannot be stalled.

  lsu_state_e  state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] addr_q, wdata_q, pc_q, rd_q;
  logic [7:0]  hi_q;
  logic        err_q;
  logic        accept, req_err;
  logic [31:0] ext_data;

  assign req_ready = (state_q == S_IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign req_err   = is_misaligned(req_op, req_addr[1:0]) || ((req_addr >> ADDR_WIDTH) != 32'd0);
  assign dm_pc     = pc_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_LW;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      pc_q    <= 32'd0;
      err_q   <= 1'b0;
      rd_q    <= 32'd0;
      hi_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        pc_q    <= req_pc;
        err_q   <= req_err;
      end
      if (state_q == S_ACC0 && !is_store(op_q))
        rd_q <= (op_q == OP_LW) ? dm_rd : {24'd0, dm_rd[7:0]};
      if (state_q == S_ACC1 && !is_store(op_q))
        hi_q <= dm_rd[7:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    dm_we      = 1'b0;
    dm_byte    = 1'b0;
    dm_addr    = 32'd0;
    dm_wd      = 32'd0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: if (accept) state_d = req_err ? S_RESP : S_ACC0;
      S_ACC0: begin
        dm_addr = addr_q;
        dm_byte = (op_q != OP_LW) && (op_q != OP_SW);
        dm_we   = is_store(op_q);
        if (op_q == OP_SW)       dm_wd = wdata_q;
        else if (is_store(op_q)) dm_wd = {24'd0, wdata_q[7:0]};
        state_d = is_half(op_q) ? S_ACC1 : S_RESP;
      end
      S_ACC1: begin
        dm_addr = addr_q + 32'd1;
        dm_byte = 1'b1;
        if (op_q == OP_SH) begin
          dm_we = 1'b1;
          dm_wd = {24'd0, wdata_q[15:8]};
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Reset wins immediately: a request caught mid-flight must not write or respond.
    if (reset) begin
      dm_we      = 1'b0;
      dm_byte    = 1'b0;
      dm_addr    = 32'd0;
      dm_wd      = 32'd0;
      resp_valid = 1'b0;
    end
  end

  m_lsu_ext u_ext (
    .op   (op_q),
    .lo   (rd_q[7:0]),
    .hi   (hi_q),
    .word (rd_q),
    .data (ext_data)
  );

  assign resp_data = (resp_valid && !err_q) ? ext_data : 32'd0;
  assign resp_err  = resp_valid && err_q;

endmodule
